// File: rtl/md5_pkg.sv
// Shared constants for the MD5 search controller.
//   LATENCY : cycles from a block at the md5core input to its digest on a..d_out
//   IV_*    : MD5 initial chaining values
//   ST_*    : controller state encoding
package md5_pkg;

    localparam int LATENCY = 65;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/md5_tag_pipe.sv
// Enable-gated shift register with synchronous clear. Carries a tag alongside
// a fixed-latency datapath so the tag leaves on the same cycle as its data.
//   clk : clock
//   clr : synchronous clear of every stage
//   en  : advance all stages by one
//   d   : tag entering stage 0
//   q   : tag in the last stage
module md5_tag_pipe
    import md5_pkg::*;
#(
    parameter int DEPTH = LATENCY,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/md5_search_ctrl.sv
// Sequencer for a fully pipelined md5core. Streams candidate blocks into the
// core, tracks each block's candidate index in a shadow pipe, compares every
// digest leaving the core against a latched target and reports hits.
//   clk, reset          : clock, synchronous active-high reset
//   start, target       : begin a search against target {a,b,c,d}
//   in_valid/in_ready   : candidate handshake; in_mesg block, in_last final one
//   core_en, core_mesg  : drive md5core
//   core_a..core_d      : md5core digest outputs
//   match_valid/idx/cnt : hit pulse, candidate index, saturating hit count
//   busy, done          : search in progress, completion pulse
//
// state | meaning
// IDLE  | waiting for start, core frozen
// RUN   | accepting candidates, core advancing every cycle
// DRAIN | no new candidates, bubbles flush the core and final compare
// DONE  | one-cycle completion pulse
module md5_search_ctrl
    import md5_pkg::*;
#(
    parameter int LATENCY = md5_pkg::LATENCY,
    parameter int IDX_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [127:0]     target,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [511:0]     in_mesg,
    input  logic             in_last,
    output logic             core_en,
    output logic [511:0]     core_mesg,
    input  logic [31:0]      core_a,
    input  logic [31:0]      core_b,
    input  logic [31:0]      core_c,
    input  logic [31:0]      core_d,
    output logic             match_valid,
    output logic [IDX_W-1:0] match_idx,
    output logic [15:0]      match_cnt,
    output logic             busy,
    output logic             done
);

    localparam int TAG_W = IDX_W + 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [IDX_W-1:0]   idx_cnt;
    logic [127:0]       target_q;
    logic [TAG_W-1:0]   tag_in_q;
    logic [TAG_W-1:0]   tag_tail;
    logic               accept;
    logic               hit;

    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign core_en  = busy;
    assign in_ready = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign accept   = in_valid && in_ready;

    // Tag stage register sits beside core_mesg so both enter their pipes together.
    assign hit = tag_tail[IDX_W] && core_en &&
                 ({core_a, core_b, core_c, core_d} == target_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            idx_cnt   <= '0;
            target_q  <= '0;
            core_mesg <= '0;
            tag_in_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        target_q <= target;
                        idx_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept && in_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= CNT_W'(LATENCY);
                    end
                end
                // LATENCY+1 drain cycles: flush the core, then one for the compare.
                ST_DRAIN: begin
                    if (drain_cnt == '0) state <= ST_DONE;
                    else                 drain_cnt <= drain_cnt - 1'b1;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            if (accept) begin
                core_mesg <= in_mesg;
                tag_in_q  <= {1'b1, idx_cnt};
                idx_cnt   <= idx_cnt + 1'b1;
            end else begin
                core_mesg <= '0;
                tag_in_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_valid <= 1'b0;
            match_idx   <= '0;
            match_cnt   <= '0;
        end else begin
            match_valid <= hit;
            if (hit) match_idx <= tag_tail[IDX_W-1:0];
            if ((state == ST_IDLE) && start)
                match_cnt <= '0;
            else if (hit && (match_cnt != 16'hFFFF))
                match_cnt <= match_cnt + 16'd1;
        end
    end

    md5_tag_pipe #(
        .DEPTH (LATENCY),
        .W     (TAG_W)
    ) u_tag_pipe (
        .clk (clk),
        .clr (reset),
        .en  (core_en),
        .d   (tag_in_q),
        .q   (tag_tail)
    );

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: two controllers (32-bit and 4-bit index) share
// stimulus, each driving its own behavioural 65-stage md5core model.
module tb_md5_search_ctrl;
    import md5_pkg::*;

    localparam logic [127:0] T_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] T_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam int DLY = LATENCY + 1;

    localparam int S_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    logic         clk, reset, start, in_valid, in_last;
    logic [127:0] target;
    logic [511:0] in_mesg;
    logic         in_ready, core_en, match_valid, busy, done;
    logic [511:0] core_mesg;
    logic [31:0]  core_a, core_b, core_c, core_d;
    logic [31:0]  match_idx;
    logic [15:0]  match_cnt;
    logic         in_ready4, core_en4, match_valid4, busy4, done4;
    logic [511:0] core_mesg4;
    logic [31:0]  core_a4, core_b4, core_c4, core_d4;
    logic [3:0]   match_idx4;
    logic [15:0]  match_cnt4;

    int cyc = 0, vec_cnt = 0, err_cnt = 0, done_cnt = 0, done_cyc = 0;
    int mq_idx[$], mq_cyc[$], m4q_idx[$];

    md5_search_ctrl #(.IDX_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .in_valid(in_valid), .in_ready(in_ready), .in_mesg(in_mesg), .in_last(in_last),
        .core_en(core_en), .core_mesg(core_mesg),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .match_valid(match_valid), .match_idx(match_idx), .match_cnt(match_cnt),
        .busy(busy), .done(done));

    md5_search_ctrl #(.IDX_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .in_valid(in_valid), .in_ready(in_ready4), .in_mesg(in_mesg), .in_last(in_last),
        .core_en(core_en4), .core_mesg(core_mesg4),
        .core_a(core_a4), .core_b(core_b4), .core_c(core_c4), .core_d(core_d4),
        .match_valid(match_valid4), .match_idx(match_idx4), .match_cnt(match_cnt4),
        .busy(busy4), .done(done4));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] md5_block(input logic [511:0] blk);
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f, w;
        int g, sh;
        for (int i = 0; i < 16; i++) begin
            w = blk[511-32*i -: 32];
            m[i] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        a = IV_A; b = IV_B; c = IV_C; d = IV_D;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
            f = f + a + K_TAB[i] + m[g];
            sh = S_TAB[(i/16)*4 + (i%4)];
            a = d; d = c; c = b;
            b = b + ((f << sh) | (f >> (32 - sh)));
        end
        return {a + IV_A, b + IV_B, c + IV_C, d + IV_D};
    endfunction

    // Behavioural md5core: LATENCY-deep, advances on core_en, shares reset.
    logic [127:0] cm_pipe  [LATENCY];
    logic [127:0] cm4_pipe [LATENCY];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) cm_pipe[i] <= '0;
        end else if (core_en) begin
            cm_pipe[0] <= md5_block(core_mesg);
            for (int i = 1; i < LATENCY; i++) cm_pipe[i] <= cm_pipe[i-1];
        end
    end
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) cm4_pipe[i] <= '0;
        end else if (core_en4) begin
            cm4_pipe[0] <= md5_block(core_mesg4);
            for (int i = 1; i < LATENCY; i++) cm4_pipe[i] <= cm4_pipe[i-1];
        end
    end
    assign {core_a, core_b, core_c, core_d}     = cm_pipe[LATENCY-1];
    assign {core_a4, core_b4, core_c4, core_d4} = cm4_pipe[LATENCY-1];

    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            mq_idx.push_back(int'(match_idx));
            mq_cyc.push_back(cyc);
        end
        if (match_valid4 === 1'b1) m4q_idx.push_back(int'(match_idx4));
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [511:0] other_blk(input int k);
        logic [511:0] r;
        r = BLK_EMPTY;
        r[479:448] = 32'(k + 1);
        return r;
    endfunction

    task automatic clear_mon();
        mq_idx.delete(); mq_cyc.delete(); m4q_idx.delete();
    endtask

    task automatic pulse_start(input logic [127:0] t);
        @(negedge clk); start = 1'b1; target = t;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send(input logic [511:0] m, input logic last, input bit st, output int acc);
        bit got = 0;
        acc = -1000;
        for (int tries = 0; tries < 50 && !got; tries++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mesg = m; in_last = last;
            if (st) begin start = 1'b1; target = T_ABC; end
            if (in_ready === 1'b1) begin got = 1; acc = cyc + 1; end
            @(posedge clk); #1 start = 1'b0;
        end
        if (!got) begin
            vec_cnt++; err_cnt++;
            $display("FAIL send_accept: in_ready never 1, expected acceptance within 50 cycles");
        end
    endtask

    task automatic bubble();
        @(negedge clk); in_valid = 1'b0; in_mesg = BLK_EMPTY; in_last = 1'b0;
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        @(negedge clk); in_valid = 1'b0; in_mesg = '0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin @(posedge clk); #2; end
        vec_cnt++;
        if (done_cnt == d0) begin
            err_cnt++;
            $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        vec_cnt++; if (core_en !== 1'b0) begin err_cnt++; $display("FAIL rst_core_en: got %b expected 0", core_en); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b expected 0", done); end
        vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_match_valid: got %b expected 0", match_valid); end
        vec_cnt++; if (core_mesg !== 512'h0) begin err_cnt++; $display("FAIL rst_core_mesg: got %0h expected 0", core_mesg); end
        vec_cnt++; if (match_idx !== 32'h0) begin err_cnt++; $display("FAIL rst_match_idx: got %0h expected 0", match_idx); end
        vec_cnt++; if (match_cnt !== 16'h0) begin err_cnt++; $display("FAIL rst_match_cnt: got %0h expected 0", match_cnt); end
        vec_cnt++; if ({in_ready4, busy4, done4} !== 3'b000) begin err_cnt++; $display("FAIL rst_dut4: got %b expected 000", {in_ready4, busy4, done4}); end
    endtask

    task automatic test_single();
        int acc, d0;
        clear_mon(); d0 = done_cnt;
        pulse_start(T_EMPTY);
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy: got %b expected 1", busy); end
        send(BLK_EMPTY, 1'b1, 1'b0, acc);
        idle_inputs();
        wait_done(d0);
        vec_cnt++; if (mq_idx.size() !== 1) begin err_cnt++; $display("FAIL single_nmatch: got %0d expected 1", mq_idx.size()); end
        vec_cnt++; if ((mq_idx.size() > 0 ? mq_idx[0] : -1) !== 0) begin err_cnt++; $display("FAIL single_idx: got %0d expected 0", mq_idx.size() > 0 ? mq_idx[0] : -1); end
        vec_cnt++; if ((mq_cyc.size() > 0 ? mq_cyc[0] - acc : -1) !== DLY) begin err_cnt++; $display("FAIL single_match_lat: got %0d expected %0d", mq_cyc.size() > 0 ? mq_cyc[0] - acc : -1, DLY); end
        vec_cnt++; if (done_cyc - acc !== DLY) begin err_cnt++; $display("FAIL single_done_lat: got %0d expected %0d", done_cyc - acc, DLY); end
        vec_cnt++; if (match_cnt !== 16'd1) begin err_cnt++; $display("FAIL single_cnt: got %0d expected 1", match_cnt); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int acc, acc0, acc57, acc99, d0;
        clear_mon(); d0 = done_cnt; acc0 = 0; acc57 = 0; acc99 = 0;
        pulse_start(T_EMPTY);
        for (int k = 0; k < 100; k++) begin
            send((k == 57) ? BLK_EMPTY : other_blk(k), k == 99, 1'b0, acc);
            if (k == 0)  acc0  = acc;
            if (k == 57) acc57 = acc;
            if (k == 99) acc99 = acc;
        end
        idle_inputs();
        wait_done(d0);
        vec_cnt++; if (acc99 - acc0 !== 99) begin err_cnt++; $display("FAIL b2b_stream: got %0d cycles expected 99", acc99 - acc0); end
        vec_cnt++; if (mq_idx.size() !== 1) begin err_cnt++; $display("FAIL b2b_nmatch: got %0d expected 1", mq_idx.size()); end
        vec_cnt++; if ((mq_idx.size() > 0 ? mq_idx[0] : -1) !== 57) begin err_cnt++; $display("FAIL b2b_idx: got %0d expected 57", mq_idx.size() > 0 ? mq_idx[0] : -1); end
        vec_cnt++; if ((mq_cyc.size() > 0 ? mq_cyc[0] - acc57 : -1) !== DLY) begin err_cnt++; $display("FAIL b2b_match_lat: got %0d expected %0d", mq_cyc.size() > 0 ? mq_cyc[0] - acc57 : -1, DLY); end
        vec_cnt++; if (done_cyc - acc99 !== DLY) begin err_cnt++; $display("FAIL b2b_done_lat: got %0d expected %0d", done_cyc - acc99, DLY); end
        vec_cnt++; if (match_cnt !== 16'd1) begin err_cnt++; $display("FAIL b2b_cnt: got %0d expected 1", match_cnt); end
        vec_cnt++; if ((m4q_idx.size() == 1 ? m4q_idx[0] : -1) !== 9) begin err_cnt++; $display("FAIL b2b_idx4: got %0d expected 9", m4q_idx.size() == 1 ? m4q_idx[0] : -1); end
    endtask

    task automatic test_gappy();
        int acc, acc3, acc9, d0;
        clear_mon(); d0 = done_cnt; acc3 = 0; acc9 = 0;
        pulse_start(T_EMPTY);
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(1, 0) == 1) bubble();
            send((k == 3 || k == 9) ? BLK_EMPTY : other_blk(k + 200), k == 11, 1'b0, acc);
            if (k == 3) acc3 = acc;
            if (k == 9) acc9 = acc;
        end
        bubble();
        idle_inputs();
        wait_done(d0);
        vec_cnt++; if (mq_idx.size() !== 2) begin err_cnt++; $display("FAIL gap_nmatch: got %0d expected 2", mq_idx.size()); end
        vec_cnt++; if ((mq_idx.size() > 0 ? mq_idx[0] : -1) !== 3) begin err_cnt++; $display("FAIL gap_idx0: got %0d expected 3", mq_idx.size() > 0 ? mq_idx[0] : -1); end
        vec_cnt++; if ((mq_idx.size() > 1 ? mq_idx[1] : -1) !== 9) begin err_cnt++; $display("FAIL gap_idx1: got %0d expected 9", mq_idx.size() > 1 ? mq_idx[1] : -1); end
        vec_cnt++; if ((mq_cyc.size() > 0 ? mq_cyc[0] - acc3 : -1) !== DLY) begin err_cnt++; $display("FAIL gap_lat0: got %0d expected %0d", mq_cyc.size() > 0 ? mq_cyc[0] - acc3 : -1, DLY); end
        vec_cnt++; if ((mq_cyc.size() > 1 ? mq_cyc[1] - acc9 : -1) !== DLY) begin err_cnt++; $display("FAIL gap_lat1: got %0d expected %0d", mq_cyc.size() > 1 ? mq_cyc[1] - acc9 : -1, DLY); end
        vec_cnt++; if (match_cnt !== 16'd2) begin err_cnt++; $display("FAIL gap_cnt: got %0d expected 2", match_cnt); end
    endtask

    task automatic test_no_match();
        int acc, d0;
        clear_mon(); d0 = done_cnt;
        pulse_start(T_ABC);
        for (int k = 0; k < 5; k++) send(BLK_EMPTY, k == 4, 1'b0, acc);
        idle_inputs();
        wait_done(d0);
        vec_cnt++; if (mq_idx.size() !== 0) begin err_cnt++; $display("FAIL nomatch_n: got %0d expected 0", mq_idx.size()); end
        vec_cnt++; if (match_cnt !== 16'd0) begin err_cnt++; $display("FAIL nomatch_cnt: got %0d expected 0", match_cnt); end
        vec_cnt++; if (done_cyc - acc !== DLY) begin err_cnt++; $display("FAIL nomatch_done_lat: got %0d expected %0d", done_cyc - acc, DLY); end
    endtask

    task automatic test_reset_mid_run();
        int acc, d0;
        clear_mon(); d0 = done_cnt;
        pulse_start(T_EMPTY);
        send(BLK_EMPTY, 1'b0, 1'b0, acc);
        send(BLK_EMPTY, 1'b0, 1'b0, acc);
        idle_inputs();
        repeat (5) @(negedge clk);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if ({in_ready, busy, core_en, done, match_valid} !== 5'b0) begin err_cnt++; $display("FAIL midrst_flags: got %b expected 00000", {in_ready, busy, core_en, done, match_valid}); end
        vec_cnt++; if (core_mesg !== 512'h0) begin err_cnt++; $display("FAIL midrst_core_mesg: got %0h expected 0", core_mesg); end
        vec_cnt++; if (match_idx !== 32'h0) begin err_cnt++; $display("FAIL midrst_match_idx: got %0h expected 0", match_idx); end
        vec_cnt++; if (match_cnt !== 16'h0) begin err_cnt++; $display("FAIL midrst_match_cnt: got %0h expected 0", match_cnt); end
        @(negedge clk); reset = 1'b0;
        repeat (120) @(negedge clk);
        vec_cnt++; if (mq_idx.size() + m4q_idx.size() !== 0) begin err_cnt++; $display("FAIL midrst_stale_match: got %0d expected 0", mq_idx.size() + m4q_idx.size()); end
        vec_cnt++; if (done_cnt !== d0) begin err_cnt++; $display("FAIL midrst_done: got %0d expected %0d", done_cnt, d0); end
    endtask

    task automatic test_start_busy_wrap();
        int acc, d0;
        clear_mon(); d0 = done_cnt;
        pulse_start(T_EMPTY);
        for (int k = 0; k < 20; k++)
            send((k == 17) ? BLK_EMPTY : other_blk(k + 500), k == 19, k == 10, acc);
        idle_inputs();
        wait_done(d0);
        vec_cnt++; if (mq_idx.size() !== 1) begin err_cnt++; $display("FAIL wrap_nmatch: got %0d expected 1", mq_idx.size()); end
        vec_cnt++; if ((mq_idx.size() > 0 ? mq_idx[0] : -1) !== 17) begin err_cnt++; $display("FAIL wrap_idx32: got %0d expected 17", mq_idx.size() > 0 ? mq_idx[0] : -1); end
        vec_cnt++; if ((m4q_idx.size() == 1 ? m4q_idx[0] : -1) !== 1) begin err_cnt++; $display("FAIL wrap_idx4: got %0d expected 1", m4q_idx.size() == 1 ? m4q_idx[0] : -1); end
        vec_cnt++; if (match_cnt !== 16'd1) begin err_cnt++; $display("FAIL wrap_cnt: got %0d expected 1", match_cnt); end
        vec_cnt++; if (match_cnt4 !== 16'd1) begin err_cnt++; $display("FAIL wrap_cnt4: got %0d expected 1", match_cnt4); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; target = '0;
        in_valid = 1'b0; in_mesg = '0; in_last = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gappy();
        test_no_match();
        test_reset_mid_run();
        test_start_busy_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
